sn_to_bn: RTL and testbench
===========================

# sn_to_bn

Stochastic-to-binary converter: the decoder end of the SNG stochastic bitstream link. It counts the ones in a stochastic bitstream over a fixed window of 2^W cycles and returns the W-bit binary value the stream encodes. It sits at the output of the stochastic compute array, and its framing signals mirror those of the SNG block: a one-cycle start pulse opens a window and a one-cycle stop pulse ends it early.

## Interface
- W, default 4: binary width. Window length N = 2^W samples.
- BIPOLAR, default 0: 0 = unipolar (x = ones). 1 = bipolar two's-complement (x = ones − N/2).

Ports:
- i_clk_s2b, in, 1: clock. One clock domain, all logic on the rising edge.
- i_rst_s2b, in, 1: reset. Synchronous, active-high.
- i_sn_bit, in, 1: stochastic stream bit. Valid every cycle while a window is open.
- i_start_s2b, in, 1: one-cycle pulse that opens or restarts a window.
- i_stop_s2b, in, 1: one-cycle pulse that closes the window early.
- o_x_bn, out, W: decoded value. Holds until the next result.
- o_valid_s2b, out, 1: one-cycle result strobe.
- o_trunc_s2b, out, 1: the result came from an early stop. Qualified by o_valid_s2b.
- o_len_s2b, out, W+1: number of samples in the result window.
- o_busy_s2b, out, 1: high while a window is open.

## Operation
- States: IDLE and COUNT.
- IDLE:
  - i_start_s2b → COUNT. Clear the ones counter and the sample counter.
  - i_stop_s2b is ignored.
- COUNT, each cycle:
  - Sample i_sn_bit. The ones counter adds the bit and the sample counter increments.
  - Both counters are W+1 bits wide.
- Normal completion: the N-th sample is taken → IDLE, result registered, o_trunc_s2b=0, o_len_s2b=N.
- Early stop: i_stop_s2b in COUNT → the bit in that same cycle is still sampled, then → IDLE, result registered, o_trunc_s2b=1, o_len_s2b=samples taken.
- Stop in the same cycle as the N-th sample: treat as normal completion, o_trunc_s2b=0.
- Start during COUNT:
  - Abandon the window with no o_valid_s2b.
  - Clear both counters.
  - The bit in that cycle is not sampled.
  - Start has priority over a simultaneous stop.
- Arithmetic, unipolar: o_x_bn = ones, saturated to 2^W−1. Example: all-ones window with ones=N gives 2^W−1.
- Arithmetic, bipolar:
  - o_x_bn = ones − (len>>1) as signed W+1, then clamped to [−2^(W−1), 2^(W−1)−1].
  - Truncated windows are not rescaled.
- Reset: state IDLE, counters 0. o_x_bn=0, o_valid_s2b=0, o_trunc_s2b=0, o_len_s2b=0, o_busy_s2b=0.
- Reset mid-window discards the window and emits no o_valid_s2b.

## Timing
- Let edge t be the edge that samples i_start_s2b=1.
- Samples are taken at edges t+1 … t+N. The bit at edge t is never counted.
- o_busy_s2b is high from after edge t until after the edge that takes the final sample.
- All outputs are registered. Result and o_valid_s2b appear after edge t+N, and o_valid_s2b drops after edge t+N+1.
- Early stop sampled at edge s: result after edge s, o_len_s2b = s−t.
- A start may be sampled in the same cycle that o_valid_s2b is high. Back-to-back windows have zero gap cycles.

## Structure
- Package sc_pkg holds:
  - state enum (S2B_IDLE, S2B_COUNT)
  - localparam helpers for N and the saturation limits
  - mode constants SC_UNIPOLAR and SC_BIPOLAR, shared with SNG
- Sub-module sn_window_counter:
  - W+1-bit ones counter and sample counter
  - clear and enable inputs
  - outputs a last-sample flag
- The top level holds the FSM, the bipolar offset and clamp, and the output registers.

## Test plan
- W=4, start, then 16 bits containing 6 ones → o_x_bn=6, o_len_s2b=16, o_trunc_s2b=0, o_valid_s2b high exactly one cycle, after edge t+16.
- 16 ones → o_x_bn=15 (saturated). 16 zeros → o_x_bn=0.
- Stop with the 8th sample, 5 ones so far → o_x_bn=5, o_trunc_s2b=1, o_len_s2b=8.
- Restart after 10 samples, then a full window of 3 ones → exactly one o_valid_s2b, o_x_bn=3.
- Reset asserted at sample 7 → all outputs 0 next cycle, no o_valid_s2b. Stop while IDLE → no effect.
- BIPOLAR=1: 12 ones → o_x_bn=4. 0 ones → −8. 16 ones → 7. Also loopback: SNG with x=6 feeding this block, 256 windows, mean o_x_bn within ±0.5 of 6.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks (SNG encoder, sn_to_bn decoder).
package sc_pkg;

  localparam int SC_UNIPOLAR = 0;
  localparam int SC_BIPOLAR  = 1;

  typedef enum logic {
    S2B_IDLE  = 1'b0,
    S2B_COUNT = 1'b1
  } s2b_state_e;

  // Window length for a W-bit value.
  function automatic int sc_n(input int w);
    return 1 << w;
  endfunction

  function automatic int sc_umax(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int sc_smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sc_smin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sn_window_counter.sv
// Ones counter and sample counter for one decode window, with look-ahead
// values that include the sample being taken this cycle.
module sn_window_counter
  import sc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W:0]   o_ones_inc,
  output logic [W:0]   o_cnt_inc,
  output logic         o_last
);

  localparam int N = sc_n(W);

  logic [W:0] ones_q, ones_d;
  logic [W:0] cnt_q, cnt_d;

  assign o_ones_inc = ones_q + {{W{1'b0}}, i_bit};
  assign o_cnt_inc  = cnt_q + (W+1)'(1);
  // The sample taken while this is high is the N-th of the window.
  assign o_last     = (cnt_q == (W+1)'(N - 1));

  always_comb begin
    ones_d = ones_q;
    cnt_d  = cnt_q;
    if (i_clr) begin
      ones_d = '0;
      cnt_d  = '0;
    end else if (i_en) begin
      ones_d = o_ones_inc;
      cnt_d  = o_cnt_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ones_q <= '0;
      cnt_q  <= '0;
    end else begin
      ones_q <= ones_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary decoder: counts ones over a 2^W window (or until an
// early stop) and registers the unipolar or bipolar binary value.
module sn_to_bn
  import sc_pkg::*;
#(
  parameter int W       = 4,
  parameter int BIPOLAR = SC_UNIPOLAR
) (
  input  logic         i_clk_s2b,
  input  logic         i_rst_s2b,
  input  logic         i_sn_bit,
  input  logic         i_start_s2b,
  input  logic         i_stop_s2b,
  output logic [W-1:0] o_x_bn,
  output logic         o_valid_s2b,
  output logic         o_trunc_s2b,
  output logic [W:0]   o_len_s2b,
  output logic         o_busy_s2b
);

  localparam logic [W-1:0]        UMAX = W'(sc_umax(W));
  localparam logic signed [W+1:0] SMAX = (W+2)'(sc_smax(W));
  localparam logic signed [W+1:0] SMIN = (W+2)'(sc_smin(W));

  s2b_state_e state_q, state_d;
  logic       clr, en, fire, trunc;
  logic [W:0] ones_inc, cnt_inc;
  logic       last;

  logic [W-1:0]        x_uni, x_bip, x_d;
  logic signed [W+1:0] diff;

  logic [W-1:0] x_q;
  logic         valid_q, trunc_q;
  logic [W:0]   len_q;

  sn_window_counter #(.W(W)) u_cnt (
    .i_clk      (i_clk_s2b),
    .i_rst      (i_rst_s2b),
    .i_clr      (clr),
    .i_en       (en),
    .i_bit      (i_sn_bit),
    .o_ones_inc (ones_inc),
    .o_cnt_inc  (cnt_inc),
    .o_last     (last)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    fire    = 1'b0;
    trunc   = 1'b0;
    case (state_q)
      S2B_IDLE: begin
        if (i_start_s2b) begin
          state_d = S2B_COUNT;
          clr     = 1'b1;
        end
      end
      S2B_COUNT: begin
        // Restart wins over stop; the bit under the restart is dropped.
        if (i_start_s2b) begin
          clr = 1'b1;
        end else begin
          en = 1'b1;
          if (last) begin
            fire    = 1'b1;
            state_d = S2B_IDLE;
          end else if (i_stop_s2b) begin
            fire    = 1'b1;
            trunc   = 1'b1;
            state_d = S2B_IDLE;
          end
        end
      end
      default: state_d = S2B_IDLE;
    endcase
  end

  always_comb begin
    x_uni = (ones_inc > {1'b0, UMAX}) ? UMAX : ones_inc[W-1:0];
    // Offset by half the actual window length; short windows are not rescaled.
    diff  = $signed({1'b0, ones_inc}) - $signed({2'b00, cnt_inc[W:1]});
    if (diff > SMAX)      x_bip = SMAX[W-1:0];
    else if (diff < SMIN) x_bip = SMIN[W-1:0];
    else                  x_bip = diff[W-1:0];
    x_d = (BIPOLAR == SC_BIPOLAR) ? x_bip : x_uni;
  end

  always_ff @(posedge i_clk_s2b) begin
    if (i_rst_s2b) begin
      state_q <= S2B_IDLE;
      x_q     <= '0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= fire;
      if (fire) begin
        x_q     <= x_d;
        trunc_q <= trunc;
        len_q   <= cnt_inc;
      end
    end
  end

  assign o_x_bn      = x_q;
  assign o_valid_s2b = valid_q;
  assign o_trunc_s2b = trunc_q;
  assign o_len_s2b   = len_q;
  assign o_busy_s2b  = (state_q == S2B_COUNT);

endmodule

// File: tb/tb_sn_to_bn.sv
// Directed bench for sn_to_bn: unipolar and bipolar instances share one
// stimulus stream; expected results are queued per window and popped on valid.
module tb_sn_to_bn;

  localparam int W = 4;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, sn_bit, start, stop;

  logic [W-1:0] xu, xb;
  logic         vu, vb, tu, tb_, bu, bb;
  logic [W:0]   lu, lb;

  always #5 clk = ~clk;

  sn_to_bn #(.W(W), .BIPOLAR(0)) u_uni (
    .i_clk_s2b(clk), .i_rst_s2b(rst), .i_sn_bit(sn_bit),
    .i_start_s2b(start), .i_stop_s2b(stop),
    .o_x_bn(xu), .o_valid_s2b(vu), .o_trunc_s2b(tu),
    .o_len_s2b(lu), .o_busy_s2b(bu)
  );

  sn_to_bn #(.W(W), .BIPOLAR(1)) u_bip (
    .i_clk_s2b(clk), .i_rst_s2b(rst), .i_sn_bit(sn_bit),
    .i_start_s2b(start), .i_stop_s2b(stop),
    .o_x_bn(xb), .o_valid_s2b(vb), .o_trunc_s2b(tb_),
    .o_len_s2b(lb), .o_busy_s2b(bb)
  );

  typedef struct {
    logic [W-1:0] xu;
    logic [W-1:0] xb;
    logic         tr;
    logic [W:0]   len;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0, nvalid = 0, sum_x = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_uni(input int ones);
    return (ones > N - 1) ? W'(N - 1) : W'(ones);
  endfunction

  function automatic logic [W-1:0] m_bip(input int ones, input int len);
    int d;
    d = ones - len / 2;
    if (d > 7)  d = 7;
    if (d < -8) d = -8;
    return W'(d);
  endfunction

  // One clock; outputs sampled on the falling edge, scoreboard popped on valid.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    chk("valid_pair", vb, vu);
    chk("busy_pair", bb, bu);
    if (vu === 1'b1) begin
      nvalid++;
      sum_x += int'(xu);
      chk("sb_nonempty", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("x_uni", xu, e.xu);
        chk("x_bip", xb, e.xb);
        chk("trunc_uni", tu, e.tr);
        chk("trunc_bip", tb_, e.tr);
        chk("len_uni", lu, e.len);
        chk("len_bip", lb, e.len);
      end
    end
  endtask

  // Start a window, feed ns samples (stop with the last one if stp).
  task automatic run_win(input logic [N-1:0] bits, input int ns, input bit stp);
    exp_t e;
    int ones, nv0;
    ones = 0;
    for (int i = 0; i < ns; i++) ones += int'(bits[i]);
    e.xu  = m_uni(ones);
    e.xb  = m_bip(ones, ns);
    e.tr  = stp && (ns < N);
    e.len = (W+1)'(ns);
    sbq.push_back(e);
    start = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("busy_open", bu, 1);
    nv0 = nvalid;
    for (int i = 0; i < ns; i++) begin
      sn_bit = bits[i];
      stop   = stp && (i == ns - 1);
      step();
    end
    sn_bit = 1'b0;
    stop   = 1'b0;
    chk("valid_at_end", vu, 1);
    chk("one_valid", nvalid - nv0, 1);
    chk("busy_closed", bu, 0);
  endtask

  initial begin
    logic [N-1:0] rb;
    int nv;
    rst = 1'b1; sn_bit = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    step();
    chk("rst_x", xu, 0);
    chk("rst_valid", vu, 0);
    chk("rst_trunc", tu, 0);
    chk("rst_len", lu, 0);
    chk("rst_busy", bu, 0);
    rst = 1'b0;
    step();

    // Stop while idle does nothing.
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_busy", bu, 0);
    chk("idle_stop_valid", vu, 0);

    // 6 ones, then check the strobe drops after one cycle.
    run_win(16'h0A63, 16, 1'b0);
    step();
    chk("valid_drop", vu, 0);
    chk("x_hold", xu, 6);

    run_win(16'hFFFF, 16, 1'b0);   // saturates to 15 / 7
    run_win(16'h0000, 16, 1'b0);   // 0 / -8
    run_win(16'h0FFF, 16, 1'b0);   // 12 ones: bipolar 4
    run_win(16'h001F, 8, 1'b1);    // early stop at 8th sample, 5 ones
    run_win(16'h3C5A, 16, 1'b1);   // stop on 16th sample: not truncated

    // Restart after 10 samples; restart cycle carries bit=1 and stop=1.
    nv = nvalid;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sn_bit = 1'b1;
      step();
    end
    sn_bit = 1'b1;
    stop   = 1'b1;
    run_win(16'h0007, 16, 1'b0);
    chk("restart_one_valid", nvalid - nv, 1);

    // Reset in the middle of a window.
    nv = nvalid;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sn_bit = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_x_uni", xu, 0);
    chk("mid_rst_x_bip", xb, 0);
    chk("mid_rst_len", lu, 0);
    chk("mid_rst_trunc", tu, 0);
    chk("mid_rst_busy", bu, 0);
    rst = 1'b0;
    sn_bit = 1'b0;
    step();
    chk("mid_rst_no_valid", nvalid - nv, 0);
    chk("mid_rst_idle", bu, 0);

    // Loopback from a p=6/16 stochastic source, windows back-to-back.
    sum_x = 0;
    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < N; i++) rb[i] = ($urandom_range(15) < 6);
      run_win(rb, 16, 1'b0);
    end
    chk("loop_mean", (sum_x >= 1408 && sum_x <= 1664), 1);

    step();
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
